// File: rtl/decode_issue.sv
// decode_issue: decodes one instruction per handshake into an ALU operation,
// reads operands from a 32x32 register file with writeback bypass, and holds
// the result in a one-entry valid/ready output register.
module decode_issue (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  out_alusignal,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_wr_en,
    output logic        illegal
);

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned REG_AW   = 5;
    localparam int unsigned OP_W     = 5;
    localparam int unsigned IMM_W    = 16;

    localparam logic [OP_W-1:0] OP_CMP  = 5'h05;
    localparam logic [OP_W-1:0] OP_AND  = 5'h06;
    localparam logic [OP_W-1:0] OP_OR   = 5'h07;
    localparam logic [OP_W-1:0] OP_LSL  = 5'h0A;
    localparam logic [OP_W-1:0] OP_LSR  = 5'h0B;
    localparam logic [OP_W-1:0] OP_ASR  = 5'h0C;
    localparam logic [OP_W-1:0] OP_NOP  = 5'h0D;
    localparam logic [OP_W-1:0] OP_LAST = 5'h0D;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [OP_W-1:0]   alusignal;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [REG_AW-1:0] rd;
        logic              wr_en;
    } issue_t;

    state_e            state_q, state_d;
    issue_t            issue_q, issue_d;
    logic              illegal_q, illegal_d;
    logic [DATA_W-1:0] rf_q [NUM_REGS];

    logic [OP_W-1:0]   op;
    logic              imm_sel;
    logic [REG_AW-1:0] rd, rs1, rs2;
    logic [IMM_W-1:0]  imm16;
    logic              legal, zero_ext, accept, load;
    logic [DATA_W-1:0] rs1_val, rs2_val, imm_ext;

    // Instruction field extraction
    assign op      = in_instr[31:27];
    assign imm_sel = in_instr[26];
    assign rd      = in_instr[25:21];
    assign rs1     = in_instr[20:16];
    assign rs2     = in_instr[15:11];
    assign imm16   = in_instr[15:0];

    // Operand read: R0 is hardwired zero, a same-cycle writeback wins over storage
    assign rs1_val = (rs1 == '0) ? '0 :
                     (wb_en && (wb_addr == rs1)) ? wb_data : rf_q[rs1];
    assign rs2_val = (rs2 == '0) ? '0 :
                     (wb_en && (wb_addr == rs2)) ? wb_data : rf_q[rs2];

    // Logical and shift ops take an unsigned immediate, everything else signed
    always_comb begin
        zero_ext = 1'b0;
        case (op)
            OP_AND, OP_OR, OP_LSL, OP_LSR, OP_ASR: zero_ext = 1'b1;
            default:                               zero_ext = 1'b0;
        endcase
    end

    assign imm_ext = zero_ext ? DATA_W'(imm16)
                              : {{(DATA_W-IMM_W){imm16[IMM_W-1]}}, imm16};

    assign legal    = (op <= OP_LAST);
    assign in_ready = !flush && ((state_q == EMPTY) || out_ready);
    assign accept   = in_valid && in_ready;
    assign load     = accept && legal;

    // Output-slot next state, payload capture and illegal-opcode pulse
    always_comb begin
        state_d   = state_q;
        issue_d   = issue_q;
        illegal_d = accept && !legal;

        case (state_q)
            EMPTY: begin
                if (load) state_d = FULL;
            end
            FULL: begin
                if (flush)          state_d = EMPTY;
                else if (load)      state_d = FULL;
                else if (out_ready) state_d = EMPTY;
            end
        endcase

        if (load) begin
            issue_d.alusignal = op;
            issue_d.a         = rs1_val;
            issue_d.b         = imm_sel ? imm_ext : rs2_val;
            issue_d.rd        = rd;
            issue_d.wr_en     = !((op == OP_CMP) || (op == OP_NOP) || (rd == '0));
        end
    end

    // Output slot and illegal flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= EMPTY;
            issue_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            issue_q   <= issue_d;
            illegal_q <= illegal_d;
        end
    end

    // Register file; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                rf_q[REG_AW'(i)] <= '0;
            end
        end else if (wb_en && (wb_addr != '0)) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    assign out_valid     = (state_q == FULL);
    assign out_alusignal = issue_q.alusignal;
    assign out_a         = issue_q.a;
    assign out_b         = issue_q.b;
    assign out_rd        = issue_q.rd;
    assign out_wr_en     = issue_q.wr_en;
    assign illegal       = illegal_q;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: scoreboard bench for decode_issue with directed scenarios
// followed by randomized traffic against a behavioural model.
module tb_decode_issue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, wb_en, out_valid, out_ready;
    logic        out_wr_en, illegal;
    logic [31:0] in_instr, wb_data, out_a, out_b;
    logic [4:0]  wb_addr, out_alusignal, out_rd;

    decode_issue dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .flush(flush), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alusignal(out_alusignal), .out_a(out_a), .out_b(out_b),
        .out_rd(out_rd), .out_wr_en(out_wr_en), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  sig;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        wr;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mregs [32];
    int          checks = 0;
    int          errors = 0;

    // Model view of the current cycle (before the next edge)
    bit cur_valid   = 1'b0;
    bit cur_illegal = 1'b0;
    bit exp_ready   = 1'b1;
    // Model state that the next edge will produce
    bit mfull       = 1'b0;
    bit nxt_illegal = 1'b0;
    bit pend_kill   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] r, input bit we,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (r == 5'd0) return 32'd0;
        if (we && wa == r) return wd;
        return mregs[r];
    endfunction

    function automatic logic [31:0] model_imm(input logic [4:0] op, input logic [15:0] imm);
        int unsigned v;
        bit unsigned_imm;
        unsigned_imm = (op == 5'h06) || (op == 5'h07) || (op == 5'h0A) ||
                       (op == 5'h0B) || (op == 5'h0C);
        if (unsigned_imm || imm < 16'h8000) v = imm;
        else v = 32'(int'(imm) - 65536);
        return v;
    endfunction

    function automatic logic [31:0] mk(input int op, input int i, input int rd,
                                       input int rs1, input int lo16);
        logic [31:0] w;
        w = {5'(op), 1'(i), 5'(rd), 5'(rs1), 16'(lo16)};
        return w;
    endfunction

    // Apply one cycle of stimulus and push the expected result on acceptance
    task automatic drive(input bit v, input logic [31:0] ins, input bit fl, input bit we,
                         input logic [4:0] wa, input logic [31:0] wd, input bit ordy_in);
        exp_t        e;
        logic [4:0]  op;
        bit          acc, ordy;
        @(posedge clk);
        #1;
        if (pend_kill) begin
            q.delete();
            pend_kill = 1'b0;
        end
        cur_valid   = mfull;
        cur_illegal = nxt_illegal;
        ordy        = fl ? 1'b0 : ordy_in;
        in_valid  = v;  in_instr = ins; flush   = fl;
        wb_en     = we; wb_addr  = wa;  wb_data = wd;
        out_ready = ordy;

        exp_ready = !fl && (!cur_valid || ordy);
        acc       = v && exp_ready;
        op        = ins[31:27];
        if (acc && op <= 5'h0D) begin
            e.sig = op;
            e.a   = model_read(ins[20:16], we, wa, wd);
            e.b   = ins[26] ? model_imm(op, ins[15:0]) : model_read(ins[15:11], we, wa, wd);
            e.rd  = ins[25:21];
            e.wr  = !(op == 5'h05 || op == 5'h0D || ins[25:21] == 5'd0);
            q.push_back(e);
        end
        nxt_illegal = acc && (op > 5'h0D);
        if (fl) begin
            mfull     = 1'b0;
            pend_kill = cur_valid;
        end else if (acc && op <= 5'h0D) mfull = 1'b1;
        else if (ordy)                    mfull = 1'b0;
        if (we && wa != 5'd0) mregs[wa] = wd;
    endtask

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
        cur_valid = 1'b0; cur_illegal = 1'b0; exp_ready = 1'b1;
        mfull = 1'b0; nxt_illegal = 1'b0; pend_kill = 1'b0;
    endtask

    // Monitor: compares handshake signals every cycle and the payload when valid
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            chk("in_ready", 32'(in_ready), 32'(exp_ready));
            chk("out_valid", 32'(out_valid), 32'(cur_valid));
            chk("illegal", 32'(illegal), 32'(cur_illegal));
            if (cur_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=valid required=entry @%0t", $time);
                end else begin
                    e = q[0];
                    chk("alusignal", 32'(out_alusignal), 32'(e.sig));
                    chk("out_a", out_a, e.a);
                    chk("out_b", out_b, e.b);
                    chk("out_rd", 32'(out_rd), 32'(e.rd));
                    chk("out_wr_en", 32'(out_wr_en), 32'(e.wr));
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [31:0] ins;
        rst_n = 1'b0;
        in_valid = 1'b0; in_instr = '0; flush = 1'b0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_alusignal", 32'(out_alusignal), 32'd0);
        chk("rst_out_a", out_a, 32'd0);
        chk("rst_out_b", out_b, 32'd0);
        chk("rst_out_rd", 32'(out_rd), 32'd0);
        chk("rst_wr_en", 32'(out_wr_en), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Basic operand read, immediate extension, bypass, R0
        drive(0, 32'd0, 0, 1, 5'd1, 32'd5, 1);
        drive(0, 32'd0, 0, 1, 5'd2, 32'd7, 1);
        drive(1, mk(5'h00, 0, 3, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h01, 1, 3, 1, 16'hFFFF), 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h06, 1, 3, 1, 16'hFFFF), 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h09, 0, 5, 4, 0), 0, 1, 5'd4, 32'hDEADBEEF, 1);
        drive(0, 32'd0, 0, 1, 5'd0, 32'h1234_5678, 1);
        drive(1, mk(5'h09, 0, 5, 0, 0), 0, 0, 5'd0, 32'd0, 1);

        // Back-pressure: fill, stall three cycles, then stream
        drive(1, mk(5'h00, 0, 7, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 1);
        for (int i = 0; i < 3; i++)
            drive(1, mk(5'h01, 0, 8, 2, 1 << 11), 0, 1, 5'd1, 32'(100 + i), 0);
        for (int i = 0; i < 4; i++)
            drive(1, mk(5'h02 + i, 0, 9 + i, 1, 4 << 11), 0, 0, 5'd0, 32'd0, 1);

        // Illegal opcode then cmp
        drive(1, mk(5'h1F, 0, 1, 1, 0), 0, 0, 5'd0, 32'd0, 1);
        drive(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h05, 0, 6, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 1);

        // Flush against a full, stalled stage with a competing input
        drive(1, mk(5'h00, 0, 3, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 0);
        drive(1, mk(5'h01, 0, 3, 1, 2 << 11), 1, 0, 5'd0, 32'd0, 0);
        drive(1, mk(5'h07, 1, 3, 1, 16'h8001), 0, 0, 5'd0, 32'd0, 1);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) < 8) ins[31:27] = 5'($urandom_range(0, 13));
            drive(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 19) == 0),
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                  1'($urandom_range(0, 9) < 7));
        end

        // Reset while an operation is held under back-pressure
        drive(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h00, 0, 3, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h01, 0, 3, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 0);
        @(posedge clk);
        #3;
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0; out_ready = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_a", out_a, 32'd0);
        model_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b1;

        // Register file must read back zero after reset
        drive(1, mk(5'h00, 0, 3, 1, 2 << 11), 0, 0, 5'd0, 32'd0, 1);
        drive(1, mk(5'h03, 0, 4, 4, 5 << 11), 0, 0, 5'd0, 32'd0, 1);
        for (int i = 0; i < 3; i++) drive(0, 32'd0, 0, 0, 5'd0, 32'd0, 1);
        chk("scoreboard_drained", 32'(q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
